// File: rtl/wbs_epb_master_pkg.sv
// Shared types and constants for the Wishbone-to-EPB initiator: FSM encoding,
// EPB idle values, window addresses and the byte-to-word address shift.
package wbs_epb_master_pkg;

    localparam int unsigned EPB_ADDR_W  = 25;
    localparam int unsigned EPB_DATA_W  = 32;
    localparam int unsigned EPB_BE_W    = 4;
    localparam int unsigned WAIT_CNT_W  = 8;
    localparam int unsigned ADDR_SHIFT  = 2;

    localparam logic [31:0] EPB_MASTER_BASE_ADDR = 32'h0001_0000;
    localparam logic [31:0] EPB_MASTER_HIGH_ADDR = 32'h0001_FFFF;

    localparam logic EPB_CS_N_IDLE      = 1'b1;
    localparam logic EPB_OE_N_IDLE      = 1'b1;
    localparam logic EPB_DATA_OE_N_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } epb_state_e;

    // Address/control payload held stable for the whole EPB cycle
    typedef struct packed {
        logic [EPB_ADDR_W-1:0] addr;
        logic [EPB_BE_W-1:0]   be_n;
        logic [EPB_DATA_W-1:0] data;
        logic                  r_w_n;
    } epb_req_t;

    localparam epb_req_t EPB_REQ_RESET = '{
        addr:  '0,
        be_n:  '1,
        data:  '0,
        r_w_n: 1'b1
    };

    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (adr >= lo) && (adr <= hi);
    endfunction

endpackage

// File: rtl/epb_wait_counter.sv
// Cycle counter shared by the SETUP dwell and the STROBE timeout; terminal
// count fires on the cycle whose closing edge completes `limit` counted cycles.
module epb_wait_counter
    import wbs_epb_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  en,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  tc_c
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign tc_c = en && (count == (limit - WAIT_CNT_W'(1)));

endmodule

// File: rtl/wbs_epb_master.sv
// Wishbone slave window that replays each accepted single-word access as one
// EPB chip-select cycle. Optional STROBE timeout enabled by `EPB_TIMEOUT_EN.
module wbs_epb_master
    import wbs_epb_master_pkg::*;
#(
    parameter int unsigned                BUS_DATA_WIDTH = 32,
    parameter int unsigned                BUS_ADDR_WIDTH = 32,
    parameter logic [BUS_ADDR_WIDTH-1:0]  DEV_BASE_ADDR  = BUS_ADDR_WIDTH'(EPB_MASTER_BASE_ADDR),
    parameter logic [BUS_ADDR_WIDTH-1:0]  DEV_HIGH_ADDR  = BUS_ADDR_WIDTH'(EPB_MASTER_HIGH_ADDR),
    parameter int unsigned                SETUP_CYCLES   = 1,
    parameter int unsigned                TIMEOUT        = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic                        epb_cs_n,
    output logic                        epb_oe_n,
    output logic                        epb_r_w_n,
    output logic [3:0]                  epb_be_n,
    output logic [5:29]                 epb_addr,
    output logic [0:BUS_DATA_WIDTH-1]   epb_data_o,
    input  logic [0:BUS_DATA_WIDTH-1]   epb_data_i,
    output logic                        epb_data_oe_n,
    input  logic                        epb_rdy
);

    epb_state_e state_q, state_d;

    epb_req_t                   req_q, req_d;
    logic                       cs_n_q, cs_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       data_oe_n_q, data_oe_n_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [BUS_DATA_WIDTH-1:0]  rdat_q, rdat_d;
    logic                       abort_q, abort_d;

    logic                       accept_c;
    logic                       setup_done_c;
    logic                       timeout_c;
    logic                       report_c;
    logic                       tc_c;
    logic                       cnt_load;
    logic                       cnt_en;
    logic [WAIT_CNT_W-1:0]      cnt_limit;
    logic [BUS_ADDR_WIDTH-1:0]  offset;
    logic [EPB_ADDR_W-1:0]      word_c;
    logic                       unused_offset;

    assign accept_c = wbs_cyc_i && wbs_stb_i &&
                      in_window(32'(wbs_adr_i), 32'(DEV_BASE_ADDR), 32'(DEV_HIGH_ADDR));

    // Window-relative word address; byte offset bits are dropped
    assign offset        = wbs_adr_i - DEV_BASE_ADDR;
    assign word_c        = offset[ADDR_SHIFT +: EPB_ADDR_W];
    assign unused_offset = ^offset;

    // Ack/err only reach the master if its cycle stayed up the whole time
    assign report_c     = wbs_cyc_i && !abort_q;
    assign setup_done_c = (state_q == ST_SETUP) && tc_c;

`ifdef EPB_TIMEOUT_EN
    assign timeout_c = (state_q == ST_STROBE) && tc_c;
    assign cnt_en    = (state_q == ST_SETUP) || (state_q == ST_STROBE);
    assign cnt_limit = (state_q == ST_SETUP) ? WAIT_CNT_W'(SETUP_CYCLES)
                                             : WAIT_CNT_W'(TIMEOUT);
`else
    logic [WAIT_CNT_W-1:0] unused_timeout;
    assign unused_timeout = WAIT_CNT_W'(TIMEOUT);
    assign timeout_c      = 1'b0;
    assign cnt_en         = (state_q == ST_SETUP);
    assign cnt_limit      = WAIT_CNT_W'(SETUP_CYCLES);
`endif

    assign cnt_load = (state_d != state_q);

    epb_wait_counter u_wait_counter (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .load  (cnt_load),
        .en    (cnt_en),
        .limit (cnt_limit),
        .tc_c  (tc_c)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c)                state_d = ST_SETUP;
            ST_SETUP:  if (setup_done_c)            state_d = ST_STROBE;
            ST_STROBE: if (epb_rdy || timeout_c)    state_d = ST_HOLD;
            ST_HOLD:                                state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Output next-values, registered below
    always_comb begin
        req_d       = req_q;
        cs_n_d      = cs_n_q;
        oe_n_d      = oe_n_q;
        data_oe_n_d = data_oe_n_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdat_d      = rdat_q;
        abort_d     = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d.addr  = word_c;
                    req_d.be_n  = ~wbs_sel_i;
                    req_d.r_w_n = ~wbs_we_i;
                    if (wbs_we_i) begin
                        req_d.data = EPB_DATA_W'(wbs_dat_i);
                    end
                    data_oe_n_d = ~wbs_we_i;
                    cs_n_d      = EPB_CS_N_IDLE;
                    oe_n_d      = EPB_OE_N_IDLE;
                    abort_d     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (setup_done_c) begin
                    cs_n_d = 1'b0;
                    oe_n_d = ~req_q.r_w_n;
                end
            end
            ST_STROBE: begin
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (epb_rdy) begin
                    cs_n_d = EPB_CS_N_IDLE;
                    oe_n_d = EPB_OE_N_IDLE;
                    ack_d  = report_c;
                    if (req_q.r_w_n) begin
                        rdat_d = epb_data_i;
                    end
                end else if (timeout_c) begin
                    cs_n_d = EPB_CS_N_IDLE;
                    oe_n_d = EPB_OE_N_IDLE;
                    err_d  = report_c;
                end
            end
            ST_HOLD: begin
                data_oe_n_d = EPB_DATA_OE_N_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            req_q       <= EPB_REQ_RESET;
            cs_n_q      <= EPB_CS_N_IDLE;
            oe_n_q      <= EPB_OE_N_IDLE;
            data_oe_n_q <= EPB_DATA_OE_N_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdat_q      <= '0;
            abort_q     <= 1'b0;
        end else begin
            req_q       <= req_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            data_oe_n_q <= data_oe_n_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdat_q      <= rdat_d;
            abort_q     <= abort_d;
        end
    end

    assign epb_cs_n      = cs_n_q;
    assign epb_oe_n      = oe_n_q;
    assign epb_r_w_n     = req_q.r_w_n;
    assign epb_be_n      = req_q.be_n;
    assign epb_addr      = req_q.addr;
    assign epb_data_o    = BUS_DATA_WIDTH'(req_q.data);
    assign epb_data_oe_n = data_oe_n_q;
    assign wbs_dat_o     = rdat_q;
    assign wbs_ack_o     = ack_q;
    assign wbs_err_o     = err_q;

endmodule
